// File: rtl/aes_stream_pkg.sv
// Shared definitions for the ROM-to-AES block streamer: block geometry,
// FSM state encoding and a byte extraction helper.
package aes_stream_pkg;

   localparam int BLK_BYTES = 16;
   localparam int BLK_W     = 128;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
      WAIT,
      WRITE,
      DONE
   } state_t;

   // Byte j of a block, byte 0 being the most significant ([127:120]).
   function automatic logic [7:0] byte_of(input logic [BLK_W-1:0] blk, input logic [3:0] j);
      logic [BLK_W-1:0] shifted;
      shifted = blk << {j, 3'b000};
      return shifted[BLK_W-1 -: 8];
   endfunction

endpackage

// File: rtl/block_pack_unpack.sv
// Datapath for one AES block: a shift-in buffer that packs ciphertext bytes
// MSB first, a load register holding the plaintext, and the byte counter
// that walks the plaintext out one byte per write cycle.
module block_pack_unpack
   import aes_stream_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en_i,
   input  logic [7:0]       shift_byte_i,
   input  logic             load_en_i,
   input  logic [BLK_W-1:0] load_data_i,
   input  logic             cnt_inc_i,
   output logic [BLK_W-1:0] pack_data_o,
   output logic [7:0]       unpack_byte_o,
   output logic [3:0]       cnt_o
);

   logic [BLK_W-1:0] pack_q;
   logic [BLK_W-1:0] unpack_q;
   logic [3:0]       cnt_q;

   // Ciphertext packing: the first byte shifted in ends up in the top byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          pack_q <= '0;
      else if (shift_en_i) pack_q <= {pack_q[BLK_W-9:0], shift_byte_i};
   end

   // Plaintext holding register, loaded once per block from the core.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         unpack_q <= '0;
      else if (load_en_i) unpack_q <= load_data_i;
   end

   // Write byte index; wraps to 0 after byte 15 so it is ready for the next block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         cnt_q <= '0;
      else if (cnt_inc_i) cnt_q <= cnt_q + 4'd1;
   end

   assign pack_data_o   = pack_q;
   assign unpack_byte_o = byte_of(unpack_q, cnt_q);
   assign cnt_o         = cnt_q;

endmodule

// File: rtl/aes_block_streamer.sv
// Byte-to-block adapter: fetches 16 ciphertext bytes from the shared ROM port
// while granted, hands the block to the AES core, and writes the plaintext
// back byte by byte into the decryption RAM.
module aes_block_streamer
   import aes_stream_pkg::*;
#(
   parameter int IMG_BYTES = 19200,
   parameter int ADDR_W    = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              active,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              core_in_valid,
   input  logic              core_in_ready,
   output logic [BLK_W-1:0]  core_in_data,
   input  logic              core_out_valid,
   input  logic [BLK_W-1:0]  core_out_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done
);

   localparam int BLK_IDX_W = ADDR_W - 4;
   localparam logic [BLK_IDX_W-1:0] LAST_BLK = BLK_IDX_W'(IMG_BYTES / BLK_BYTES - 1);

   state_t                state_q, state_d;
   logic [BLK_IDX_W-1:0]  blk_q;
   logic [BLK_IDX_W-1:0]  blk_inc;
   logic [4:0]            k_q;       // next byte to issue, 16 = all issued
   logic [4:0]            k_inc, k_dec;
   logic                  pend_q;    // a byte issued last cycle is due back now
   logic [ADDR_W-1:0]     rom_addr_q;
   logic                  done_q;
   logic [3:0]            cnt;

   logic start_acc, issue, capture, discard, load_en, cnt_inc, next_blk;

   assign k_inc   = k_q + 5'd1;
   assign k_dec   = k_q - 5'd1;
   assign blk_inc = blk_q + 1'b1;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle control strobes. Issue and discard are mutually
   // exclusive because one needs active=1 and the other active=0.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      issue     = 1'b0;
      capture   = 1'b0;
      discard   = 1'b0;
      load_en   = 1'b0;
      cnt_inc   = 1'b0;
      next_blk  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            if (active) begin
               capture = pend_q;
               issue   = !k_q[4];
               if (pend_q && k_q[4]) state_d = SEND;
            end else begin
               discard = pend_q;
            end
         end
         SEND: begin
            if (core_in_ready) state_d = WAIT;
         end
         WAIT: begin
            if (core_out_valid) begin
               load_en = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            cnt_inc = 1'b1;
            if (cnt == 4'hF) begin
               if (blk_q == LAST_BLK) begin
                  state_d = DONE;
               end else begin
                  next_blk = 1'b1;
                  state_d  = FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fetch bookkeeping. rom_addr always shows the byte to issue next; a byte
   // whose return cycle lost the grant is rolled back so it is reissued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q      <= '0;
         k_q        <= '0;
         pend_q     <= 1'b0;
         rom_addr_q <= '0;
      end else if (start_acc) begin
         blk_q      <= '0;
         k_q        <= '0;
         pend_q     <= 1'b0;
         rom_addr_q <= '0;
      end else if (next_blk) begin
         blk_q      <= blk_inc;
         k_q        <= '0;
         pend_q     <= 1'b0;
         rom_addr_q <= {blk_inc, 4'd0};
      end else if (issue) begin
         k_q    <= k_inc;
         pend_q <= 1'b1;
         if (k_q[3:0] != 4'hF) rom_addr_q <= {blk_q, k_inc[3:0]};
      end else if (discard) begin
         k_q        <= k_dec;
         pend_q     <= 1'b0;
         rom_addr_q <= {blk_q, k_dec[3:0]};
      end else if (capture) begin
         pend_q <= 1'b0;
      end
   end

   // Completion flag: set on entering DONE, held until the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                done_q <= 1'b0;
      else if (start_acc)        done_q <= 1'b0;
      else if (state_d == DONE)  done_q <= 1'b1;
   end

   block_pack_unpack u_pack (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_en_i   (capture),
      .shift_byte_i (rom_data),
      .load_en_i    (load_en),
      .load_data_i  (core_out_data),
      .cnt_inc_i    (cnt_inc),
      .pack_data_o  (core_in_data),
      .unpack_byte_o(wr_data),
      .cnt_o        (cnt)
   );

   assign rom_addr      = rom_addr_q;
   assign core_in_valid = (state_q == SEND);
   assign wr_en         = (state_q == WRITE);
   assign wr_addr       = {blk_q, cnt};
   assign busy          = (state_q == FETCH) || (state_q == SEND) ||
                          (state_q == WAIT)  || (state_q == WRITE);
   assign done          = done_q;

endmodule

// File: tb/tb_aes_block_streamer.sv
// Directed bench for aes_block_streamer with a 32-byte image (two blocks),
// a synchronous ROM model returning addr^key, an XOR-0xFF core with 3-cycle
// latency and a RAM model capturing every write.
module tb_aes_block_streamer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         active;
   logic [14:0]  rom_addr;
   logic [7:0]   rom_data;
   logic         core_in_valid;
   logic         core_in_ready;
   logic [127:0] core_in_data;
   logic         core_out_valid;
   logic [127:0] core_out_data;
   logic         wr_en;
   logic [14:0]  wr_addr;
   logic [7:0]   wr_data;
   logic         busy;
   logic         done;

   logic [7:0]   rom_key = 8'h00;
   logic         inj_valid = 1'b0;
   logic [2:0]   v_pipe = 3'b000;
   logic [127:0] d_pipe0, d_pipe1, d_pipe2;
   logic [7:0]   ram [0:31];
   int           wr_cnt = 0;
   int           hs_cnt = 0;
   logic [127:0] hs_data = '0;

   int checks = 0;
   int errors = 0;
   int wr0, hs0, n;

   aes_block_streamer #(.IMG_BYTES(32), .ADDR_W(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .active        (active),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .core_in_valid (core_in_valid),
      .core_in_ready (core_in_ready),
      .core_in_data  (core_in_data),
      .core_out_valid(core_out_valid),
      .core_out_data (core_out_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   assign core_out_valid = v_pipe[2] | inj_valid;
   assign core_out_data  = inj_valid ? 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF : d_pipe2;

   // ROM, core and RAM models plus transaction counters.
   always @(posedge clk) begin
      rom_data <= rom_addr[7:0] ^ rom_key;
      v_pipe   <= {v_pipe[1:0], core_in_valid & core_in_ready};
      d_pipe0  <= core_in_data ^ {16{8'hFF}};
      d_pipe1  <= d_pipe0;
      d_pipe2  <= d_pipe1;
      if (wr_en) begin
         ram[wr_addr[4:0]] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (core_in_valid && core_in_ready) begin
         hs_cnt  <= hs_cnt + 1;
         hs_data <= core_in_data;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_rom_addr", rom_addr, 0);
      check("rst_core_in_valid", core_in_valid, 0);
      check("rst_core_in_data", core_in_data, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
   endtask

   // One full pass from a start pulse to done, with optional extra starts
   // (restart_at, +20, +50) and an optional spurious core_out_valid.
   task automatic run_pass(input logic [7:0] key, input int restart_at, input int inj_at);
      rom_key = key;
      wr0     = wr_cnt;
      hs0     = hs_cnt;
      start   = 1'b1;
      n       = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         start     = (n == restart_at) || (n == restart_at + 20) || (n == restart_at + 50);
         inj_valid = (n == inj_at);
         if (n == 1) begin
            check("busy_after_start", busy, 1);
            check("done_cleared", done, 0);
         end
         if (inj_at > 0 && n == inj_at + 1) begin
            check("no_write_on_spurious", wr_en, 0);
            check("busy_after_spurious", busy, 1);
         end
         if (done) break;
      end
      start     = 1'b0;
      inj_valid = 1'b0;
      check("pass_cycles", n, 75);
   endtask

   // Post-pass checks: flags, write/handshake counts and RAM contents.
   task automatic finish_pass(input logic [7:0] key);
      check("done_level", done, 1);
      check("busy_in_done", busy, 0);
      check("write_count", wr_cnt - wr0, 32);
      check("handshake_count", hs_cnt - hs0, 2);
      for (int i = 0; i < 32; i++) begin
         logic [7:0] exp_b;
         exp_b = 8'(i) ^ key ^ 8'hFF;
         check($sformatf("ram[%0d]", i), ram[i], exp_b);
      end
      @(negedge clk);
      check("done_held_idle", done, 1);
      check("busy_idle", busy, 0);
      $display("pass key=%02h cycles=%0d writes=%0d handshakes=%0d", key, n, wr_cnt - wr0, hs_cnt - hs0);
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      active        = 1'b1;
      core_in_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst_n = 1'b1;
      @(negedge clk);

      // Basic pass, ROM[i]=i, core XOR 0xFF.
      run_pass(8'h00, -1000, -1000);
      check("last_block_data", hs_data, 128'h101112131415161718191A1B1C1D1E1F);
      finish_pass(8'h00);

      // Toggling grant during fetch, then core_in_ready held low in SEND.
      rom_key       = 8'h30;
      core_in_ready = 1'b0;
      wr0           = wr_cnt;
      hs0           = hs_cnt;
      start         = 1'b1;
      n             = 0;
      while (!core_in_valid && n < 400) begin
         @(negedge clk);
         n++;
         start  = 1'b0;
         active = (n <= 8) ? n[0] : (((n - 9) % 4) < 2);
      end
      active = 1'b1;
      check("send_reached", core_in_valid, 1);
      check("toggle_block_data", core_in_data, 128'h303132333435363738393A3B3C3D3E3F);
      repeat (10) begin
         @(negedge clk);
         check("valid_held", core_in_valid, 1);
         check("data_stable", core_in_data, 128'h303132333435363738393A3B3C3D3E3F);
      end
      check("no_early_handshake", hs_cnt - hs0, 0);
      core_in_ready = 1'b1;
      @(negedge clk);
      check("valid_dropped", core_in_valid, 0);
      check("one_handshake", hs_cnt - hs0, 1);
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      finish_pass(8'h30);

      // Start pulses while busy must not disturb the pass.
      run_pass(8'h60, 10, -1000);
      finish_pass(8'h60);

      // Spurious core_out_valid during fetch.
      run_pass(8'h90, -1000, 5);
      finish_pass(8'h90);

      // Reset in the middle of the first block's write phase at j=5.
      rom_key = 8'hC0;
      wr0     = wr_cnt;
      start   = 1'b1;
      n       = 0;
      while (!(wr_en && wr_addr == 15'd5) && n < 400) begin
         @(negedge clk);
         n++;
         start = 1'b0;
      end
      check("j5_cycle", n, 27);
      check("j5_addr", wr_addr, 5);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      check("partial_writes", wr_cnt - wr0, 5);
      check("partial_ram4", ram[4], 8'h3B);
      check("untouched_ram5", ram[5], 8'h6A);
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("late_valid_no_write", wr_cnt - wr0, 5);
      check("late_valid_idle", busy, 0);
      run_pass(8'hE0, -1000, -1000);
      finish_pass(8'hE0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
